// File: rtl/write_ptr_sync_controller_pkg.sv
// Shared FIFO pointer definitions and gray/binary helpers used by both pointer controllers.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package write_ptr_sync_controller_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int FIFO_DEPTH = 2 ** DEF_ADDR_W;

    // Functions work on a 32-bit zero-extended value, so any pointer width up to 32 bits can
    // share them; callers truncate the result back to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all gray bits at and above it.
    function automatic logic [31:0] gray2bin(input logic [31:0] gray);
        logic [31:0] bin;
        bin[31] = gray[31];
        for (int i = 30; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/write_ptr_sync_controller_if.sv
// Bundle of the write-side pointer controller's producer and cross-domain signals.
// Latency: none (wiring only).
// Backpressure: full tells the producer to stop; writes while full are dropped and flagged.
interface write_ptr_sync_controller_if
    import write_ptr_sync_controller_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              w_en;
    logic [ADDR_W-1:0] r_add_gray;
    logic [ADDR_W-1:0] w_add;
    logic [ADDR_W-1:0] w_add_gray_synch;
    logic              full;
    logic              almost_full;
    logic              overflow;
    logic [ADDR_W-1:0] w_level;

    // Producer / environment side.
    modport master (
        output w_en,
        output r_add_gray,
        input  w_add,
        input  w_add_gray_synch,
        input  full,
        input  almost_full,
        input  overflow,
        input  w_level
    );

    // Controller side.
    modport slave (
        input  w_en,
        input  r_add_gray,
        output w_add,
        output w_add_gray_synch,
        output full,
        output almost_full,
        output overflow,
        output w_level
    );
endinterface

// File: rtl/write_ptr_sync_controller_ptr_sync_ff.sv
// Multi-flop synchronizer bringing a gray-coded pointer into the local clock domain.
// Latency: STAGES clock edges from a stable input to the output.
// Backpressure: none; samples every cycle.
module ptr_sync_ff #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             w_clk,
    input  logic             w_reset,
    input  logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] sync_out
);

    logic [WIDTH-1:0] sync_q [STAGES];

    // Shift the pointer through the flop chain; reset clears every stage in one edge.
    always_ff @(posedge w_clk) begin
        if (w_reset) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= sync_in;
            for (int i = 1; i < STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/write_ptr_sync_controller.sv
// Write-side async FIFO pointer controller: write address, gray export, full/almost_full/level.
// Latency: accepted write advances w_add at the next edge; read pointer seen after SYNC_STAGES edges.
// Backpressure: full drops writes and pulses overflow for one cycle; full is pessimistic.
module write_ptr_sync_controller
    import write_ptr_sync_controller_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int SYNC_STAGES = 2,
    parameter int AF_THRESH   = 28
) (
    input  logic                       w_clk,
    input  logic                       w_reset,
    write_ptr_sync_controller_if.slave bus
);

    localparam logic [ADDR_W:0] AF_LVL = (ADDR_W + 1)'(AF_THRESH);

    logic [ADDR_W-1:0] w_add_q;
    logic [ADDR_W-1:0] w_add_gray_q;
    logic              overflow_q;
    logic [ADDR_W-1:0] w_add_inc;
    logic [ADDR_W-1:0] w_add_d;
    logic [ADDR_W-1:0] r_gray_sync;
    logic [ADDR_W-1:0] r_add_synched;
    logic [ADDR_W-1:0] level;
    logic              full_c;
    logic              write_ok;

    ptr_sync_ff #(
        .WIDTH  (ADDR_W),
        .STAGES (SYNC_STAGES)
    ) u_r_ptr_sync (
        .w_clk    (w_clk),
        .w_reset  (w_reset),
        .sync_in  (bus.r_add_gray),
        .sync_out (r_gray_sync)
    );

    assign r_add_synched = ADDR_W'(gray2bin(32'(r_gray_sync)));

    // One slot is kept empty so equal pointers always mean empty on the read side.
    assign w_add_inc = w_add_q + ADDR_W'(1);
    assign full_c    = (w_add_inc == r_add_synched);
    assign level     = w_add_q - r_add_synched;
    assign write_ok  = bus.w_en & ~full_c;

    // Next write address: advance only on an accepted write, wrapping naturally.
    always_comb begin
        w_add_d = w_add_q;
        if (write_ok) begin
            w_add_d = w_add_inc;
        end
    end

    // Pointer, exported gray pointer and overflow pulse; the gray copy is taken from the same
    // next value so it never lags the binary address.
    always_ff @(posedge w_clk) begin
        if (w_reset) begin
            w_add_q      <= '0;
            w_add_gray_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            w_add_q      <= w_add_d;
            w_add_gray_q <= ADDR_W'(bin2gray(32'(w_add_d)));
            overflow_q   <= bus.w_en & full_c;
        end
    end

    assign bus.w_add            = w_add_q;
    assign bus.w_add_gray_synch = w_add_gray_q;
    assign bus.full             = full_c;
    assign bus.w_level          = level;
    assign bus.almost_full      = ({1'b0, level} >= AF_LVL);
    assign bus.overflow         = overflow_q;

endmodule

// File: doc/write_ptr_sync_controller.md
Name: write_ptr_sync_controller

Overview:
Write-side pointer controller for the asynchronous FIFO, running entirely in the write clock domain. It produces the binary write address for FIFO memory and synchronizes the read controller's gray pointer into w_clk. It derives full, almost_full, overflow and fill level, and exports a registered gray write pointer for the read domain to synchronize.

Parameters:
ADDR_W, 5, pointer/address width; FIFO has 2**ADDR_W slots, usable capacity 2**ADDR_W-1
SYNC_STAGES, 2, flop stages in the read-pointer synchronizer (legal values 2..3)
AF_THRESH, 28, fill level at or above which almost_full asserts

Ports:
w_clk  input  1  write-domain clock; all state updates on rising edge
w_reset  input  1  synchronous, active-high reset, sampled on rising w_clk
w_en  input  1  write request from producer
r_add_gray  input  ADDR_W  gray read pointer from the read controller's registered output; asynchronous to w_clk
w_add  output  ADDR_W  binary write address to FIFO memory
w_add_gray_synch  output  ADDR_W  registered gray write pointer, sent to the read domain
full  output  1  no free slot; writes are dropped
almost_full  output  1  level >= AF_THRESH
overflow  output  1  one-cycle pulse: a write was attempted while full
w_level  output  ADDR_W  occupancy as seen from the write domain

Behaviour:
- Reset (w_reset=1 at a w_clk edge): w_add, w_add_gray_synch, all synchronizer flops, and overflow clear to 0. Consequently full=0, almost_full=0, w_level=0 in the first cycle after reset. Reset wins over w_en. Mid-fill reset discards all state in that single edge.
- Synchronizer: r_add_gray passes through SYNC_STAGES flops. The last stage is gray-to-binary converted combinationally to r_add_synched. Latency is SYNC_STAGES w_clk edges from a stable input to a visible effect.
- full: combinational, 1 when (w_add + 1) mod 2**ADDR_W == r_add_synched. One slot always stays empty, so the read side's empty test (binary equality) remains unambiguous.
- w_level: combinational, (w_add - r_add_synched) mod 2**ADDR_W; range 0..2**ADDR_W-1.
- almost_full: combinational, w_level >= AF_THRESH. It is implied whenever full=1, provided AF_THRESH <= 2**ADDR_W-1.
- Accepted write (w_en & ~full): w_add increments by 1 at the edge. It wraps from 2**ADDR_W-1 to 0 with no special casing (modulo arithmetic). The memory writes at the pre-increment w_add.
- Rejected write (w_en & full): w_add holds. overflow=1 in the following cycle only (registered pulse, not sticky).
- No write (w_en=0): all pointers hold. overflow=0 next cycle.
- w_add_gray_synch: registered every cycle as binary-to-gray of the w_add value being registered, so it always equals gray(w_add) with no extra lag. Exactly one bit changes per increment, including on wrap.
- The read pointer advancing while the write side is full: full clears SYNC_STAGES edges after r_add_gray changes. A write in that same cycle is judged against the current (stale) full flag. Full is pessimistic, never optimistic.
- No combinational path from r_add_gray to any output; all outputs depend only on flops (plus w_add and synchronized values).

Decomposition:
- Shared fifo package holds: ADDR_W default, FIFO_DEPTH = 2**ADDR_W, and the gray/binary conversion functions. The read controller uses the same functions, keeping both sides consistent.
- One sub-module, ptr_sync_ff: parameterised width and stage count, synchronous active-high reset, instantiated once for r_add_gray.
- BinaryToGray is reused for the write-pointer conversion.

Test Plan:
1. Reset: w_en=1 held during w_reset=1 -> w_add=0, w_add_gray_synch=0, full=0, w_level=0, overflow=0 after release.
2. Fill to full: r_add_gray=0; 31 cycles of w_en=1 -> w_add=31, w_level=31, full=1. almost_full rises when w_level reaches 28, i.e. on the cycle w_add becomes 28. A 32nd write leaves w_add=31 and produces overflow=1 for exactly one cycle.
3. Drain visibility: from full, set r_add_gray=gray(4)=5'b00110 -> full stays 1 for 1 cycle, is 0 after the 2nd edge (SYNC_STAGES=2), w_level=27, almost_full=0.
4. Wrap-around: r_add_synched=20 (r_add_gray=gray(20)=5'b11110), w_add=30; 3 writes -> w_add sequence 31, 0, 1. Gray output is 10000, 00000, 00001 (one bit change each step). full=0, w_level=13.
5. Reset mid-fill: after 10 writes, assert w_reset for 1 cycle with w_en=1 -> w_add=0 and sync flops cleared next edge; writes resume from address 0.
6. Simultaneous full and drain: w_add=31, r_add_synched=0; the r_add_gray update and w_en=1 arrive in the same cycle -> the write is rejected and overflow pulses. The retried write is accepted once full deasserts 2 edges later.
